spi_rx_state: RTL and testbench
===============================

Name: spi_rx_state

Overview:
- SPI receiver (peripheral side) for the 3-wire link driven by the team's SPI transmitter: spi_cs_l, spi_sclk, spi_data.
- Oversamples the link in the system clk domain and reassembles MSB-first 16-bit frames.
- Presents each completed word on a parallel bus with a one-cycle valid strobe.
- Flags frames aborted early by chip-select deassertion.

Parameters:
- DATA_WIDTH, 16, bits per frame; must be ≥2.
- SYNC_STAGES, 2, flip-flop synchroniser depth on each SPI input; must be ≥2.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- spi_cs_l  input  1  chip select, active low.
- spi_sclk  input  1  serial clock; idles low.
- spi_data  input  1  serial data; transmitter changes it on sclk falling edge.
- dataout  output  DATA_WIDTH  last complete received word.
- data_valid  output  1  one-clk pulse; dataout updated in the same cycle.
- frame_err  output  1  one-clk pulse on early chip-select deassertion.
- busy  output  1  high while state is RECV or WAIT_CS.
- counter  output  5  bits received in the current frame, 0..DATA_WIDTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - dataout=0, data_valid=0, frame_err=0, busy=0, counter=0.
  - Shift register cleared.
  - Synchronisers preset: cs_l=1, sclk=0, data=0.
  - Reset mid-frame discards the partial word; no strobe is issued.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops.
  - sclk rising edge = synced sclk is 1 and its previous synced value is 0; same rule for falling edge.
  - Requirement: spi_sclk high and low phases are each ≥2 clk periods (sclk ≤ clk/4).
- Sampling: on a detected sclk rising edge in RECV:
  - shift = {shift[DATA_WIDTH-2:0], synced data}.
  - counter increments by 1.
- IDLE:
  - busy=0, counter=0.
  - Synced cs_l falling (1→0) → RECV; shift and counter cleared.
  - sclk edges in IDLE are ignored.
- RECV:
  - If the rising edge that makes counter reach DATA_WIDTH is detected:
    - Next cycle: dataout ← completed word, data_valid=1 for exactly one cycle.
    - State → WAIT_CS.
  - If synced cs_l goes high with counter < DATA_WIDTH:
    - frame_err=1 for one cycle; dataout unchanged; state → IDLE; counter → 0.
    - This applies even when counter=0 (CS pulse with no clocks).
  - cs_l high and the final rising edge detected in the same cycle: the edge wins, word completes, no frame_err.
- WAIT_CS:
  - busy=1; counter holds DATA_WIDTH.
  - Extra sclk edges are ignored; no wrap into a new word.
  - Synced cs_l high → IDLE, counter → 0.
- Back-to-back frames: a new cs_l falling edge is accepted once IDLE has been re-entered. The transmitter's CS-high gap is ≥1 sclk period.
- Latency: pin rising edge of the 16th sclk to data_valid = SYNC_STAGES+2 clk cycles.
- data_valid and frame_err are never high in the same cycle.

Test Plan:
- Reset held low 2 cycles, then released; one frame MSB-first 0xA569 at sclk=clk/8:
  - exactly one data_valid pulse; dataout=0xA569; counter sequence 0→16; busy falls after cs_l high.
- Three consecutive frames 0x2563, 0x9B63, 0x6A61 with a 1-sclk CS gap:
  - three data_valid pulses with dataout in that order; frame_err never asserted.
- Frame 0x7564 aborted by cs_l high after 7 bits:
  - frame_err one-cycle pulse; no data_valid; dataout keeps its previous value (0x6A61); counter=0; state IDLE.
- 18 sclk pulses in one CS window carrying 0xA265 then bits 1,1:
  - dataout=0xA265; single data_valid; extra edges ignored; counter held at 16 until cs_l high.
- reset asserted after bit 9 of 0xFFFF, released, then frame 0x0001 sent:
  - outputs go to 0 immediately (asynchronously); no strobe from the aborted frame; next data_valid shows 0x0001.
- cs_l toggled low→high with no sclk:
  - one frame_err pulse; dataout unchanged.

Source files
------------

// File: rtl/spi_rx_state.sv
// Peripheral-side SPI receiver: oversamples cs_l/sclk/data in the clk domain and
// reassembles MSB-first frames, strobing complete words and flagging early aborts.
module spi_rx_state #(
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_cs_l,
   input  logic                  spi_sclk,
   input  logic                  spi_data,
   output logic [DATA_WIDTH-1:0] dataout,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic                  busy,
   output logic [4:0]            counter
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECV    = 2'd1,
      WAIT_CS = 2'd2
   } state_t;

   localparam logic [4:0] CNT_FULL = 5'(DATA_WIDTH);
   localparam logic [4:0] CNT_LAST = 5'(DATA_WIDTH - 1);

   logic [SYNC_STAGES-1:0] cs_sync_r;
   logic [SYNC_STAGES-1:0] sclk_sync_r;
   logic [SYNC_STAGES-1:0] data_sync_r;
   logic                   cs_prev_r;
   logic                   sclk_prev_r;

   logic                   cs_s;
   logic                   sclk_s;
   logic                   data_s;
   logic                   cs_fall_s;
   logic                   sclk_rise_s;

   state_t                 state_r;
   state_t                 state_nx_s;
   logic [DATA_WIDTH-1:0]  shift_r;
   logic [DATA_WIDTH-1:0]  shift_nx_s;
   logic [4:0]             counter_r;
   logic [4:0]             counter_nx_s;
   logic                   done_r;
   logic                   done_nx_s;
   logic                   frame_err_r;
   logic                   ferr_nx_s;
   logic                   busy_r;
   logic                   busy_nx_s;
   logic [DATA_WIDTH-1:0]  dataout_r;
   logic                   data_valid_r;

   // Input synchronisers; presets match an idle link (deselected, sclk low).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_sync_r   <= {SYNC_STAGES{1'b1}};
         sclk_sync_r <= {SYNC_STAGES{1'b0}};
         data_sync_r <= {SYNC_STAGES{1'b0}};
         cs_prev_r   <= 1'b1;
         sclk_prev_r <= 1'b0;
      end else begin
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_l};
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
         data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], spi_data};
         cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
         sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
      end
   end

   assign cs_s        = cs_sync_r[SYNC_STAGES-1];
   assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
   assign data_s      = data_sync_r[SYNC_STAGES-1];
   assign cs_fall_s   = cs_prev_r & ~cs_s;
   assign sclk_rise_s = sclk_s & ~sclk_prev_r;

   // Next-state logic; the final sampling edge takes priority over a CS abort.
   always_comb begin
      state_nx_s   = state_r;
      shift_nx_s   = shift_r;
      counter_nx_s = counter_r;
      done_nx_s    = 1'b0;
      ferr_nx_s    = 1'b0;
      case (state_r)
         IDLE: begin
            counter_nx_s = 5'd0;
            if (cs_fall_s) begin
               state_nx_s = RECV;
               shift_nx_s = {DATA_WIDTH{1'b0}};
            end else begin
               state_nx_s = IDLE;
            end
         end
         RECV: begin
            if (sclk_rise_s && (counter_r == CNT_LAST)) begin
               shift_nx_s   = {shift_r[DATA_WIDTH-2:0], data_s};
               counter_nx_s = CNT_FULL;
               done_nx_s    = 1'b1;
               state_nx_s   = WAIT_CS;
            end else if (cs_s) begin
               counter_nx_s = 5'd0;
               ferr_nx_s    = 1'b1;
               state_nx_s   = IDLE;
            end else if (sclk_rise_s) begin
               shift_nx_s   = {shift_r[DATA_WIDTH-2:0], data_s};
               counter_nx_s = counter_r + 5'd1;
            end else begin
               state_nx_s = RECV;
            end
         end
         WAIT_CS: begin
            if (cs_s) begin
               counter_nx_s = 5'd0;
               state_nx_s   = IDLE;
            end else begin
               counter_nx_s = CNT_FULL;
               state_nx_s   = WAIT_CS;
            end
         end
         default: begin
            counter_nx_s = 5'd0;
            state_nx_s   = IDLE;
         end
      endcase
      busy_nx_s = (state_nx_s == RECV) || (state_nx_s == WAIT_CS);
   end

   // State, shift register and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         shift_r     <= {DATA_WIDTH{1'b0}};
         counter_r   <= 5'd0;
         done_r      <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         shift_r     <= shift_nx_s;
         counter_r   <= counter_nx_s;
         done_r      <= done_nx_s;
         frame_err_r <= ferr_nx_s;
         busy_r      <= busy_nx_s;
      end
   end

   // Word is published the cycle after the last bit lands in the shifter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataout_r    <= {DATA_WIDTH{1'b0}};
         data_valid_r <= 1'b0;
      end else if (done_r) begin
         dataout_r    <= shift_r;
         data_valid_r <= 1'b1;
      end else begin
         data_valid_r <= 1'b0;
      end
   end

   assign dataout    = dataout_r;
   assign data_valid = data_valid_r;
   assign frame_err  = frame_err_r;
   assign busy       = busy_r;
   assign counter    = counter_r;

   spi_rx_state_chk #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_chk (
      .clk        (clk),
      .reset      (reset),
      .data_valid (data_valid_r),
      .frame_err  (frame_err_r),
      .busy       (busy_r),
      .counter    (counter_r)
   );

endmodule

// Protocol invariants of the receiver outputs.
module spi_rx_state_chk #(
   parameter int DATA_WIDTH = 16
) (
   input logic       clk,
   input logic       reset,
   input logic       data_valid,
   input logic       frame_err,
   input logic       busy,
   input logic [4:0] counter
);

   a_no_overlap: assert property (@(posedge clk) disable iff (!reset)
      !(data_valid && frame_err));

   a_valid_pulse: assert property (@(posedge clk) disable iff (!reset)
      data_valid |=> !data_valid);

   a_err_pulse: assert property (@(posedge clk) disable iff (!reset)
      frame_err |=> !frame_err);

   a_cnt_range: assert property (@(posedge clk) disable iff (!reset)
      counter <= 5'(DATA_WIDTH));

   a_idle_cnt: assert property (@(posedge clk) disable iff (!reset)
      !busy |-> (counter == 5'd0));

endmodule

// File: tb/tb_spi_rx_state.sv
// Directed bench for spi_rx_state: table of frames plus hand-written reset sequence.
module tb_spi_rx_state;

   logic        clk;
   logic        reset;
   logic        spi_cs_l;
   logic        spi_sclk;
   logic        spi_data;
   logic [15:0] dataout;
   logic        data_valid;
   logic        frame_err;
   logic        busy;
   logic [4:0]  counter;

   int n_pass  = 0;
   int n_total = 0;
   int dv_cnt  = 0;
   int fe_cnt  = 0;
   int both    = 0;
   logic [15:0] last_dv = 16'h0000;

   typedef struct {
      logic [15:0] word;
      int          nbits;
      int          extra;
      logic [15:0] exp_data;
      int          exp_dv;
      int          exp_fe;
   } vec_t;

   vec_t vecs[7];

   spi_rx_state #(
      .DATA_WIDTH  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .spi_cs_l   (spi_cs_l),
      .spi_sclk   (spi_sclk),
      .spi_data   (spi_data),
      .dataout    (dataout),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy),
      .counter    (counter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (reset) begin
         if (data_valid) begin
            dv_cnt  = dv_cnt + 1;
            last_dv = dataout;
         end
         if (frame_err) fe_cnt = fe_cnt + 1;
         if (data_valid && frame_err) both = both + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else n_pass = n_pass + 1;
   endtask

   // One CS window at sclk = clk/8; bits past 16 are sent as 1.
   task automatic send(input logic [15:0] w, input int nbits, input int extra,
                       input bit chk_cnt, input bit end_cs);
      logic b;
      spi_cs_l = 1'b0;
      tick(4);
      if (chk_cnt) chk("busy_in_frame", {31'd0, busy}, 32'd1);
      for (int i = 0; i < nbits + extra; i++) begin
         if (i < 16) b = w[15-i];
         else b = 1'b1;
         spi_data = b;
         tick(4);
         spi_sclk = 1'b1;
         tick(4);
         if (chk_cnt) chk("counter_step", {27'd0, counter}, (i < 16) ? i + 1 : 16);
         spi_sclk = 1'b0;
      end
      if (end_cs) begin
         tick(4);
         spi_cs_l = 1'b1;
         tick(8);
      end
   endtask

   initial begin
      int dv0;
      int fe0;
      vecs[0] = '{16'hA569, 16, 0, 16'hA569, 1, 0};
      vecs[1] = '{16'h2563, 16, 0, 16'h2563, 1, 0};
      vecs[2] = '{16'h9B63, 16, 0, 16'h9B63, 1, 0};
      vecs[3] = '{16'h6A61, 16, 0, 16'h6A61, 1, 0};
      vecs[4] = '{16'h7564,  7, 0, 16'h6A61, 0, 1};
      vecs[5] = '{16'hA265, 16, 2, 16'hA265, 1, 0};
      vecs[6] = '{16'h0000,  0, 0, 16'hA265, 0, 1};

      reset    = 1'b0;
      spi_cs_l = 1'b1;
      spi_sclk = 1'b0;
      spi_data = 1'b0;
      tick(2);
      chk("rst_dataout", {16'd0, dataout}, 32'd0);
      chk("rst_valid", {31'd0, data_valid}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_counter", {27'd0, counter}, 32'd0);
      reset = 1'b1;
      tick(4);

      for (int i = 0; i < 7; i++) begin
         dv0 = dv_cnt;
         fe0 = fe_cnt;
         send(vecs[i].word, vecs[i].nbits, vecs[i].extra,
              (i == 0) || (vecs[i].extra > 0), 1'b1);
         tick(4);
         chk("vec_dv_count", dv_cnt - dv0, vecs[i].exp_dv);
         chk("vec_fe_count", fe_cnt - fe0, vecs[i].exp_fe);
         chk("vec_dataout", {16'd0, dataout}, {16'd0, vecs[i].exp_data});
         chk("vec_busy_idle", {31'd0, busy}, 32'd0);
         chk("vec_counter_idle", {27'd0, counter}, 32'd0);
         if (vecs[i].exp_dv > 0) chk("vec_strobed_word", {16'd0, last_dv}, {16'd0, vecs[i].exp_data});
      end

      // Asynchronous reset in the middle of a frame of all ones.
      dv0 = dv_cnt;
      send(16'hFFFF, 9, 0, 1'b0, 1'b0);
      tick(2);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      chk("pre_rst_counter", {27'd0, counter}, 32'd9);
      reset = 1'b0;
      #1;
      chk("async_rst_dataout", {16'd0, dataout}, 32'd0);
      chk("async_rst_counter", {27'd0, counter}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      tick(2);
      spi_cs_l = 1'b1;
      reset    = 1'b1;
      tick(8);
      chk("no_strobe_after_rst", dv_cnt - dv0, 32'd0);
      fe0 = fe_cnt;
      send(16'h0001, 16, 0, 1'b0, 1'b1);
      tick(4);
      chk("post_rst_dv_count", dv_cnt - dv0, 32'd1);
      chk("post_rst_dataout", {16'd0, dataout}, 32'h0001);
      chk("post_rst_fe_count", fe_cnt - fe0, 32'd0);

      chk("no_dv_fe_overlap", both, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
